// File: rtl/uart_cmd_assembler.sv
// Packs two consecutive UART bytes (high byte first) into a 16-bit command
// with a level ready/acknowledge handshake, inter-byte timeout and overrun flag.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned TMO_W          = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        ovr_err,
  output logic        tmo_err
);

  typedef enum logic {WAIT_HI, WAIT_LO} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic [7:0]       hi_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [15:0]      cmd_reg;
  logic             cmd_rdy_reg;
  logic             ovr_err_reg;
  logic             tmo_err_reg;
  logic             complete;

  // Every byte is taken on the first cycle it is visible, in either state.
  assign clr_rx_rdy = !rst && rx_rdy;
  assign complete   = (state_reg == WAIT_LO) && rx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= WAIT_HI;
      hi_reg      <= 8'h00;
      tmo_cnt_reg <= '0;
      cmd_reg     <= 16'h0000;
      cmd_rdy_reg <= 1'b0;
      ovr_err_reg <= 1'b0;
      tmo_err_reg <= 1'b0;
    end else begin
      tmo_err_reg <= 1'b0;

      case (state_reg)
        WAIT_HI: begin
          if (rx_rdy) begin
            hi_reg      <= rx_data;
            tmo_cnt_reg <= '0;
            state_reg   <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          // A byte arriving on the terminal-count cycle takes priority.
          if (rx_rdy) begin
            state_reg   <= WAIT_HI;
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg   <= WAIT_HI;
            tmo_cnt_reg <= '0;
            tmo_err_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        default: begin
          state_reg   <= WAIT_HI;
          tmo_cnt_reg <= '0;
        end
      endcase

      // An acknowledge in the completion cycle frees the slot for the new command.
      if (complete) begin
        if (cmd_rdy_reg && !clr_cmd_rdy) begin
          ovr_err_reg <= 1'b1;
        end else begin
          cmd_reg     <= {hi_reg, rx_data};
          cmd_rdy_reg <= 1'b1;
        end
      end else if (clr_cmd_rdy) begin
        cmd_rdy_reg <= 1'b0;
        ovr_err_reg <= 1'b0;
      end
    end
  end

  assign cmd     = cmd_reg;
  assign cmd_rdy = cmd_rdy_reg;
  assign ovr_err = ovr_err_reg;
  assign tmo_err = tmo_err_reg;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: vector table for byte pairs,
// hand-written timeout / boundary / reset sequences, and a command scoreboard.
module tb_uart_cmd_assembler;

  localparam int unsigned TMO  = 100;
  localparam int unsigned GAP  = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        ovr_err;
  logic        tmo_err;

  int checks    = 0;
  int fails     = 0;
  int clr_cnt   = 0;
  int sent      = 0;
  logic [15:0] sb[$];
  logic [15:0] prev_cmd = 16'h0;
  logic        prev_rdy = 1'b0;

  uart_cmd_assembler #(.TIMEOUT_CYCLES(TMO), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .ovr_err(ovr_err), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each newly loaded command is popped and compared.
  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt++;
    if (!rst && cmd_rdy && (!prev_rdy || cmd != prev_cmd)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_cmd", {16'h0, cmd}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_cmd", {16'h0, cmd}, {16'h0, sb.pop_front()});
        $display("cmd out %h", cmd);
      end
    end
    prev_rdy <= cmd_rdy;
    prev_cmd <= cmd;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    chk("clr_rx_rdy_pulse", {31'h0, clr_rx_rdy}, 32'h1);
    tick();
    rx_rdy = 1'b0;
    sent++;
    $display("byte in %h", b);
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  typedef struct {
    logic        do_ack;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
    logic        exp_ovr;
    logic        exp_load;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] cur_cmd;
    vecs[0] = '{1'b0, 8'hA5, 8'h3C, 16'hA53C, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h01, 8'h02, 16'h0102, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'hEE, 16'h0102, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h5A, 8'hC3, 16'h5AC3, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 8'h11, 8'h22, 16'h5AC3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 8'h7F, 16'h807F, 1'b0, 1'b1};

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd", {16'h0, cmd}, 32'h0);
    chk("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("rst_ovr", {31'h0, ovr_err}, 32'h0);
    chk("rst_tmo", {31'h0, tmo_err}, 32'h0);
    tick();
    cur_cmd = 16'h0000;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_ack) begin
        ack();
        @(negedge clk);
        chk("ack_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("ack_ovr", {31'h0, ovr_err}, 32'h0);
        chk("ack_cmd_kept", {16'h0, cmd}, {16'h0, cur_cmd});
        tick();
      end
      send_byte(vecs[i].hi);
      repeat (GAP) tick();
      if (vecs[i].exp_load) sb.push_back(vecs[i].exp_cmd);
      send_byte(vecs[i].lo);
      @(negedge clk);
      chk("vec_cmd", {16'h0, cmd}, {16'h0, vecs[i].exp_cmd});
      chk("vec_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
      chk("vec_ovr", {31'h0, ovr_err}, {31'h0, vecs[i].exp_ovr});
      chk("vec_tmo", {31'h0, tmo_err}, 32'h0);
      cur_cmd = vecs[i].exp_cmd;
      tick();
    end

    // Timeout: high byte then silence; pulse exactly TMO cycles later.
    ack();
    send_byte(8'h12);
    for (int c = 1; c <= int'(TMO); c++) begin
      tick();
      if (c >= int'(TMO) - 1)
        chk("tmo_pulse", {31'h0, tmo_err}, {31'h0, (c == int'(TMO))});
    end
    tick();
    chk("tmo_single", {31'h0, tmo_err}, 32'h0);
    send_byte(8'h34);
    repeat (GAP) tick();
    sb.push_back(16'h3456);
    send_byte(8'h56);
    @(negedge clk);
    chk("post_tmo_cmd", {16'h0, cmd}, 32'h3456);
    tick();

    // Low byte on the terminal-count cycle, with an acknowledge in the same cycle.
    send_byte(8'h66);
    repeat (int'(TMO) - 1) tick();
    rx_data = 8'h77; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    sb.push_back(16'h6677);
    tick();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; sent++;
    chk("tc_cmd", {16'h0, cmd}, 32'h6677);
    chk("tc_cmd_rdy", {31'h0, cmd_rdy}, 32'h1);
    chk("tc_tmo", {31'h0, tmo_err}, 32'h0);
    chk("tc_ovr", {31'h0, ovr_err}, 32'h0);
    tick();
    chk("tc_tmo_after", {31'h0, tmo_err}, 32'h0);

    // Reset mid-command; a byte already waiting during reset must not be consumed.
    send_byte(8'h9A);
    rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'hBC;
    @(negedge clk);
    chk("rst_clr_rx_rdy", {31'h0, clr_rx_rdy}, 32'h0);
    tick();
    rst = 1'b0;
    chk("mid_rst_cmd", {16'h0, cmd}, 32'h0);
    chk("mid_rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    chk("mid_rst_flags", {30'h0, ovr_err, tmo_err}, 32'h0);
    @(negedge clk);
    chk("post_rst_clr_rx_rdy", {31'h0, clr_rx_rdy}, 32'h1);
    tick();
    rx_rdy = 1'b0; sent++;
    repeat (GAP) tick();
    sb.push_back(16'hBCDE);
    send_byte(8'hDE);
    @(negedge clk);
    chk("rst_seq_cmd", {16'h0, cmd}, 32'hBCDE);
    chk("rst_seq_flags", {30'h0, ovr_err, tmo_err}, 32'h0);
    repeat (3) tick();

    chk("sb_drained", sb.size(), 32'h0);
    chk("clr_rx_rdy_count", clr_cnt, sent);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes its rdy/rx_data/clr_rdy byte handshake and packs two consecutive bytes, high byte first, into a 16-bit command.
- Presents the command to the command-processing logic with a level cmd_rdy / clr_cmd_rdy handshake.
- An inter-byte timeout resynchronises framing when a low byte never arrives; an overrun flag reports commands dropped while the consumer is busy.

Parameters:
TIMEOUT_CYCLES, 200000, clk cycles allowed in WAIT_LO before the held high byte is discarded (about 4 byte times at 5208 clk/bit); must be >= 2.
TMO_W, 18, width of the timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset, sampled on rising clk.
rx_rdy  input  1  byte-available level from the UART receiver; stays high until cleared.
rx_data  input  8  received byte; valid while rx_rdy=1.
clr_rx_rdy  output  1  combinational one-cycle consume strobe back to the UART receiver.
cmd  output  16  assembled command {high byte, low byte}.
cmd_rdy  output  1  level: cmd holds an unconsumed command.
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
ovr_err  output  1  sticky: a completed command was dropped because cmd_rdy was still set.
tmo_err  output  1  one-cycle pulse: the held high byte was discarded on timeout.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - state=WAIT_HI, cmd=16'h0000, cmd_rdy=0, ovr_err=0, tmo_err=0, high-byte register=0, timeout counter=0.
  - clr_rx_rdy is forced 0 in any cycle where rst=1.
- States:
  - WAIT_HI: waiting for the high byte.
  - WAIT_LO: high byte held; waiting for the low byte.
- Consume rule: clr_rx_rdy = !rst & rx_rdy, in either state.
  - Each byte is consumed in the same cycle it is first seen.
  - The UART's rdy is low on the following cycle, so every byte is taken exactly once.
- WAIT_HI with rx_rdy=1:
  - hi_reg <= rx_data; timeout counter <= 0; next state WAIT_LO.
- WAIT_LO with rx_rdy=1:
  - Next state WAIT_HI; timeout counter <= 0.
  - If cmd_rdy=1 and clr_cmd_rdy=0: cmd unchanged, cmd_rdy stays 1, ovr_err <= 1. The new command is dropped.
  - Otherwise: cmd <= {hi_reg, rx_data}, cmd_rdy <= 1.
  - Simultaneous completion and clr_cmd_rdy: the new command loads, cmd_rdy stays 1, no overrun.
- WAIT_LO with rx_rdy=0:
  - Counter increments each cycle.
  - On the cycle the counter equals TIMEOUT_CYCLES-1: next state WAIT_HI, counter <= 0, tmo_err <= 1 for exactly one cycle, hi_reg contents are irrelevant thereafter.
- Simultaneous rx_rdy=1 and timeout terminal count: the byte wins (normal completion, no tmo_err).
- Counter holds at 0 in WAIT_HI. tmo_err is 0 in every cycle except the single timeout pulse.
- clr_cmd_rdy=1 with no concurrent completion: cmd_rdy <= 0; cmd retains its value; ovr_err <= 0.
  - ovr_err is otherwise sticky.
  - clr_cmd_rdy does not affect state or hi_reg.
- Latency: cmd and cmd_rdy are valid the cycle after the edge at which the low byte is seen with rx_rdy=1.
- rst asserted mid-command (WAIT_LO): the held high byte is discarded, the next byte received is treated as a high byte, and no error flags are raised.
- Arithmetic: the timeout counter is unsigned TMO_W bits and never wraps, since it is cleared at terminal count.

Test Plan:
1. Reset, then bytes 8'hA5 and 8'h3C presented ~52k cycles apart:
   - clr_rx_rdy pulses once per byte.
   - cmd=16'hA53C and cmd_rdy=1 one cycle after the second byte.
   - ovr_err=0, tmo_err=0.
2. From test 1, pulse clr_cmd_rdy:
   - cmd_rdy=0 next cycle; cmd stays 16'hA53C.
   - Then send 8'h01, 8'h02: cmd=16'h0102, cmd_rdy=1.
3. Overrun: leave cmd_rdy=1 (cmd=16'h0102) and send 8'hFF, 8'hEE:
   - cmd stays 16'h0102, ovr_err=1.
   - Then clr_cmd_rdy: ovr_err=0, cmd_rdy=0.
4. Timeout with TIMEOUT_CYCLES=100: send 8'h12, then nothing:
   - tmo_err=1 for one cycle exactly 100 cycles later; state returns to WAIT_HI.
   - Then send 8'h34, 8'h56: cmd=16'h3456.
5. Boundary: low byte 8'h77 arrives on the terminal-count cycle after high byte 8'h66, with clr_cmd_rdy=1 on that same cycle and cmd_rdy=1 beforehand:
   - cmd=16'h6677, cmd_rdy=1, tmo_err=0, ovr_err=0.
6. Reset mid-command: send 8'h9A, assert rst one cycle, then send 8'hBC, 8'hDE:
   - cmd=16'hBCDE, and outputs were at reset values immediately after the rst cycle.
